restoring_divider6by3: RTL and testbench
========================================

Name: restoring_divider6by3

Overview:
- Sequential inverse of the team's 3x3 combinational multiplier.
- Takes a 2*W-bit dividend (e.g. a 6-bit product) and a W-bit divisor, and recovers the W-bit quotient and W-bit remainder.
- Uses restoring division, one quotient bit per clock, with a start/done handshake.
- Serves as the check path and inverse operator alongside the multiplier in the arithmetic test datapath.

Parameters:
- W, 3, operand width; dividend is 2*W bits, divisor/quotient/remainder are W bits each.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request pulse; accepted only in IDLE.
- dividend  input  2*W  numerator; sampled on the accepting edge.
- divisor  input  W  denominator; sampled on the accepting edge.
- busy  output  1  high from the edge after acceptance until the edge that raises done.
- done  output  1  one-cycle pulse; result outputs are valid while high and held afterwards.
- quotient  output  W  result quotient.
- remainder  output  W  result remainder.
- div_by_zero  output  1  error flag for the last operation.
- overflow  output  1  error flag for the last operation: quotient does not fit in W bits.

Behaviour:
- Reset (rst=1 at an edge, any state):
  - state returns to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
  - Any operation in progress is discarded with no done pulse.
  - rst has priority over start.
- States are IDLE, CALC and DONE.
- IDLE:
  - When start=1, latch the dividend and divisor.
  - Clear div_by_zero and overflow at the same edge.
  - If divisor==0: go to DONE with div_by_zero=1, quotient=all ones, remainder=0.
  - Else, if dividend[2W-1:W] >= divisor: go to DONE with overflow=1, quotient=all ones, remainder=0.
  - Else: set the partial remainder R (W+1 bits) = {0, dividend[2W-1:W]}, set step counter=W-1, go to CALC, busy=1.
- CALC (W cycles, one per edge):
  - T = {R[W-1:0], next dividend bit}, taking dividend bits from W-1 down to 0.
  - If T >= {0, divisor}: R = T - divisor and the quotient bit = 1. Otherwise R = T and the quotient bit = 0.
  - Quotient bits are shifted in MSB-first.
  - On the edge processing bit 0: go to DONE, drive quotient and remainder = R[W-1:0].
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE on the next edge.
  - Results and flags hold until the next accepted start or reset.
- Latency:
  - Normal case: start accepted at edge k, done high in the cycle following edge k+W+1... more precisely, done is asserted by edge k+W and is high for one cycle.
  - Error cases: done is asserted by edge k+1.
  - A new start may be accepted one edge after done, giving a throughput of one operation per W+2 cycles.
- start is ignored while busy=1 or done=1. There is no queuing, and inputs may change freely while busy.
- Invariant on every normal completion: quotient*divisor + remainder == dividend, and remainder < divisor.
- All comparisons and subtractions are unsigned. The W+1-bit R is sufficient and nothing is truncated.

Test Plan:
- Reset mid-operation: rst for 2 cycles, then start with 42/6, then rst asserted at the 2nd CALC edge -> no done pulse, all outputs 0, and a following start of 20/3 completes normally.
- W=3, dividend=42, divisor=6, start pulse -> done exactly 3 edges after acceptance, quotient=7, remainder=0, flags 0, busy high for 3 cycles.
- Back-to-back operations, each started the cycle after done: 20/3 -> quotient=6, remainder=2. 45/7 -> quotient=6, remainder=3. 1/7 -> quotient=0, remainder=1. Also start held high during busy -> exactly one done per accepted start.
- Error cases:
  - 13/0 -> done 1 edge after start, div_by_zero=1, quotient=7, remainder=0.
  - 40/5 -> overflow=1, quotient=7, remainder=0.
  - A following start of 35/5 clears both flags and gives quotient=7, remainder=0.
- Exhaustive sweep: all dividend 0..63 and divisor 0..7 -> the flags match the rules above, and every non-error result satisfies quotient*divisor+remainder==dividend with remainder<divisor.

Source files
------------

// File: rtl/restoring_divider6by3.sv
// restoring_divider6by3: sequential restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per clock
module restoring_divider6by3 #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [2*W-1:0] dvd;
  logic [W-1:0] dvs, q, qn;
  logic [W:0] r, t, rn;
  logic [CW-1:0] cnt;
  logic ge;
  always_comb begin
    t = {r[W-1:0], dvd[cnt]};
    ge = t >= {1'b0, dvs};
    rn = ge ? t - {1'b0, dvs} : t;
    qn = {q[W-2:0], ge};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
      dvd <= '0;
      dvs <= '0;
      q <= '0;
      r <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd <= dividend;
          dvs <= divisor;
          div_by_zero <= 1'b0;
          overflow <= 1'b0;
          if (divisor == '0) begin
            div_by_zero <= 1'b1;
            quotient <= '1;
            remainder <= '0;
            done <= 1'b1;
            state <= DONE;
          end else if (dividend[2*W-1:W] >= divisor) begin
            // upper half >= divisor means the quotient needs more than W bits
            overflow <= 1'b1;
            quotient <= '1;
            remainder <= '0;
            done <= 1'b1;
            state <= DONE;
          end else begin
            r <= {1'b0, dividend[2*W-1:W]};
            q <= '0;
            cnt <= CW'(W - 1);
            busy <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          r <= rn;
          q <= qn;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient <= qn;
            remainder <= rn[W-1:0];
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_restoring_divider6by3.sv
// tb_restoring_divider6by3: directed and sweep checks for the restoring divider
module tb_restoring_divider6by3;
  logic clk = 1'b0;
  logic rst, start, busy, done, div_by_zero, overflow;
  logic [5:0] dividend;
  logic [2:0] divisor, quotient, remainder;
  int checks = 0;
  int errors = 0;

  restoring_divider6by3 #(.W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic go(input logic [5:0] a, input logic [2:0] b);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc = int'(busy);
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      bc += int'(busy);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout done=%b required 1", done);
    end
  endtask

  task automatic test_reset;
    int lat, bc, dn;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0", {busy, done, quotient, remainder, div_by_zero, overflow});
    end
    @(negedge clk);
    rst = 1'b0;
    go(6'd42, 3'd6);
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midop_busy got %b required 1", busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 10'b0) begin
      errors++;
      $display("FAIL midop_reset_outputs got %b required 0", {busy, done, quotient, remainder, div_by_zero, overflow});
    end
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      dn += int'(done);
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL midop_no_done got %0d done pulses required 0", dn);
    end
    go(6'd20, 3'd3);
    wait_done(lat, bc);
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {3'd6, 3'd2, 2'b00}) begin
      errors++;
      $display("FAIL after_reset_20_3 got q=%0d r=%0d dz=%b ov=%b required q=6 r=2 dz=0 ov=0", quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_basic;
    int lat, bc;
    @(posedge clk);
    go(6'd42, 3'd6);
    wait_done(lat, bc);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL basic_latency got %0d required 3", lat);
    end
    checks++;
    if (bc != 3) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d required 3", bc);
    end
    checks++;
    if ({busy, quotient, remainder, div_by_zero, overflow} !== {1'b0, 3'd7, 3'd0, 2'b00}) begin
      errors++;
      $display("FAIL basic_42_6 got busy=%b q=%0d r=%0d dz=%b ov=%b required busy=0 q=7 r=0 dz=0 ov=0", busy, quotient, remainder, div_by_zero, overflow);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done, quotient, remainder} !== {1'b0, 3'd7, 3'd0}) begin
      errors++;
      $display("FAIL basic_hold got done=%b q=%0d r=%0d required done=0 q=7 r=0", done, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] a [3] = '{6'd20, 6'd45, 6'd1};
    logic [2:0] b [3] = '{3'd3, 3'd7, 3'd7};
    logic [2:0] eq [3] = '{3'd6, 3'd6, 3'd0};
    logic [2:0] er [3] = '{3'd2, 3'd3, 3'd1};
    int lat, bc, dn;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      go(a[i], b[i]);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_accept_%0d busy=%b required 1", i, busy);
      end
      wait_done(lat, bc);
      checks++;
      if ({quotient, remainder, div_by_zero, overflow} !== {eq[i], er[i], 2'b00}) begin
        errors++;
        $display("FAIL b2b_%0d got q=%0d r=%0d dz=%b ov=%b required q=%0d r=%0d", i, quotient, remainder, div_by_zero, overflow, eq[i], er[i]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    dividend = 6'd42;
    divisor = 3'd6;
    start = 1'b1;
    dn = 0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      dn += int'(done);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      dn += int'(done);
    end
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL held_start_done_count got %0d required 1", dn);
    end
  endtask

  task automatic test_errors;
    int lat, bc;
    @(posedge clk);
    go(6'd13, 3'd0);
    wait_done(lat, bc);
    checks++;
    if (lat > 1) begin
      errors++;
      $display("FAIL dz_latency got %0d required <=1", lat);
    end
    checks++;
    if ({busy, quotient, remainder, div_by_zero, overflow} !== {1'b0, 3'd7, 3'd0, 2'b10}) begin
      errors++;
      $display("FAIL dz_13_0 got busy=%b q=%0d r=%0d dz=%b ov=%b required busy=0 q=7 r=0 dz=1 ov=0", busy, quotient, remainder, div_by_zero, overflow);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done, div_by_zero} !== 2'b01) begin
      errors++;
      $display("FAIL dz_pulse_hold got done=%b dz=%b required done=0 dz=1", done, div_by_zero);
    end
    go(6'd40, 3'd5);
    wait_done(lat, bc);
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {3'd7, 3'd0, 2'b01}) begin
      errors++;
      $display("FAIL ov_40_5 got q=%0d r=%0d dz=%b ov=%b required q=7 r=0 dz=0 ov=1", quotient, remainder, div_by_zero, overflow);
    end
    @(posedge clk);
    go(6'd35, 3'd5);
    checks++;
    if ({div_by_zero, overflow} !== 2'b00) begin
      errors++;
      $display("FAIL flags_clear got dz=%b ov=%b required 00", div_by_zero, overflow);
    end
    wait_done(lat, bc);
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {3'd7, 3'd0, 2'b00}) begin
      errors++;
      $display("FAIL norm_35_5 got q=%0d r=%0d dz=%b ov=%b required q=7 r=0 dz=0 ov=0", quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_sweep;
    int lat, bc;
    logic [2:0] xq, xr;
    logic xdz, xov;
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 8; b++) begin
        xdz = (b == 0);
        xov = !xdz && ((a >> 3) >= b);
        xq = (xdz || xov) ? 3'd7 : 3'(a / b);
        xr = (xdz || xov) ? 3'd0 : 3'(a % b);
        @(posedge clk);
        go(6'(a), 3'(b));
        wait_done(lat, bc);
        checks++;
        if ({quotient, remainder, div_by_zero, overflow} !== {xq, xr, xdz, xov}) begin
          errors++;
          $display("FAIL sweep_%0d_%0d got q=%0d r=%0d dz=%b ov=%b required q=%0d r=%0d dz=%b ov=%b", a, b, quotient, remainder, div_by_zero, overflow, xq, xr, xdz, xov);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
